// File: rtl/region_stats_if.sv
// rtl/region_stats_if.sv - pixel stream in / frame statistics out bundle for region_stats
interface region_stats_if #(
    parameter int XW = 9,
    parameter int YW = 8,
    parameter int CW = 17,
    parameter int SW = 26
);
    logic          pix_valid;
    logic          pix_sof;
    logic [7:0]    pix_data;
    logic          stats_valid;
    logic          obj_present;
    logic [CW-1:0] pix_count;
    logic [XW-1:0] min_x;
    logic [XW-1:0] max_x;
    logic [YW-1:0] min_y;
    logic [YW-1:0] max_y;
    logic [SW-1:0] sum_x;
    logic [SW-1:0] sum_y;
    logic          frame_err;

    modport master (
        output pix_valid, pix_sof, pix_data,
        input  stats_valid, obj_present, pix_count, min_x, max_x,
               min_y, max_y, sum_x, sum_y, frame_err
    );

    modport slave (
        input  pix_valid, pix_sof, pix_data,
        output stats_valid, obj_present, pix_count, min_x, max_x,
               min_y, max_y, sum_x, sum_y, frame_err
    );
endinterface

// File: rtl/region_stats.sv
// rtl/region_stats.sv - per-frame blob count, bounding box and coordinate sums (sums under REGION_STATS_SUMS_EN)
module region_stats #(
    parameter int IMG_W = 320,
    parameter int IMG_H = 240,
    parameter int XW    = 9,
    parameter int YW    = 8,
    parameter int CW    = 17,
    parameter int SW    = 26
) (
    input  logic          clk,
    input  logic          rst,
    region_stats_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t        state;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [CW-1:0] acc_count;
    logic [XW-1:0] acc_min_x, acc_max_x;
    logic [YW-1:0] acc_min_y, acc_max_y;

    logic          beat_en, fresh, obj, base_has, last_pix;
    logic [XW-1:0] cur_x, n_x, base_min_x, base_max_x, n_min_x, n_max_x;
    logic [YW-1:0] cur_y, n_y, base_min_y, base_max_y, n_min_y, n_max_y;
    logic [CW-1:0] base_count, n_count;

    // A beat that opens a frame (from IDLE/DONE, or a restarting sof) sees
    // zeroed accumulators so stale values never leak into the new frame.
    always_comb begin
        beat_en    = bus.pix_valid && (state == ACCUM || bus.pix_sof);
        fresh      = (state != ACCUM) || bus.pix_sof;
        obj        = bus.pix_data != 8'd0;
        cur_x      = fresh ? '0 : x;
        cur_y      = fresh ? '0 : y;
        base_count = fresh ? '0 : acc_count;
        base_min_x = fresh ? '0 : acc_min_x;
        base_max_x = fresh ? '0 : acc_max_x;
        base_min_y = fresh ? '0 : acc_min_y;
        base_max_y = fresh ? '0 : acc_max_y;
        base_has   = base_count != '0;
        n_count    = base_count + CW'(obj);
        n_min_x    = base_min_x;
        n_max_x    = base_max_x;
        n_min_y    = base_min_y;
        n_max_y    = base_max_y;
        if (obj) begin
            n_min_x = (base_has && base_min_x < cur_x) ? base_min_x : cur_x;
            n_max_x = (base_has && base_max_x > cur_x) ? base_max_x : cur_x;
            n_min_y = (base_has && base_min_y < cur_y) ? base_min_y : cur_y;
            n_max_y = (base_has && base_max_y > cur_y) ? base_max_y : cur_y;
        end
        last_pix = (cur_x == XW'(IMG_W - 1)) && (cur_y == YW'(IMG_H - 1));
        if (cur_x == XW'(IMG_W - 1)) begin
            n_x = '0;
            n_y = cur_y + YW'(1);
        end else begin
            n_x = cur_x + XW'(1);
            n_y = cur_y;
        end
    end

    // The last beat latches the final values directly, so stats_valid is
    // high during the single DONE cycle that follows it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            x               <= '0;
            y               <= '0;
            acc_count       <= '0;
            acc_min_x       <= '0;
            acc_max_x       <= '0;
            acc_min_y       <= '0;
            acc_max_y       <= '0;
            bus.stats_valid <= 1'b0;
            bus.obj_present <= 1'b0;
            bus.pix_count   <= '0;
            bus.min_x       <= '0;
            bus.max_x       <= '0;
            bus.min_y       <= '0;
            bus.max_y       <= '0;
            bus.frame_err   <= 1'b0;
        end else begin
            bus.stats_valid <= 1'b0;
            bus.frame_err   <= 1'b0;
            if (beat_en) begin
                acc_count <= n_count;
                acc_min_x <= n_min_x;
                acc_max_x <= n_max_x;
                acc_min_y <= n_min_y;
                acc_max_y <= n_max_y;
                if (state == ACCUM && bus.pix_sof && !(x == '0 && y == '0))
                    bus.frame_err <= 1'b1;
                if (last_pix) begin
                    x               <= '0;
                    y               <= '0;
                    state           <= DONE;
                    bus.stats_valid <= 1'b1;
                    bus.obj_present <= n_count != '0;
                    bus.pix_count   <= n_count;
                    bus.min_x       <= n_min_x;
                    bus.max_x       <= n_max_x;
                    bus.min_y       <= n_min_y;
                    bus.max_y       <= n_max_y;
                end else begin
                    x     <= n_x;
                    y     <= n_y;
                    state <= ACCUM;
                end
            end else if (state == DONE) begin
                state <= IDLE;
            end
        end
    end

`ifdef REGION_STATS_SUMS_EN
    logic [SW-1:0] acc_sum_x, acc_sum_y, n_sum_x, n_sum_y;

    always_comb begin
        n_sum_x = fresh ? '0 : acc_sum_x;
        n_sum_y = fresh ? '0 : acc_sum_y;
        if (obj) begin
            n_sum_x = n_sum_x + SW'(cur_x);
            n_sum_y = n_sum_y + SW'(cur_y);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_sum_x <= '0;
            acc_sum_y <= '0;
            bus.sum_x <= '0;
            bus.sum_y <= '0;
        end else if (beat_en) begin
            acc_sum_x <= n_sum_x;
            acc_sum_y <= n_sum_y;
            if (last_pix) begin
                bus.sum_x <= n_sum_x;
                bus.sum_y <= n_sum_y;
            end
        end
    end
`else
    assign bus.sum_x = '0;
    assign bus.sum_y = '0;
`endif
endmodule

// File: tb/tb_region_stats.sv
// tb/tb_region_stats.sv - randomized frames against a per-frame statistics model for region_stats
module tb_region_stats;
    localparam int W = 8, H = 4, N = W * H;
    localparam int XW = 3, YW = 2, CW = 6, SW = 9;

    typedef struct {
        int cnt, min_x, max_x, min_y, max_y, sx, sy;
    } stats_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    stats_t prev;
    logic [7:0] img [N];

    region_stats_if #(.XW(XW), .YW(YW), .CW(CW), .SW(SW)) bus ();

    region_stats #(.IMG_W(W), .IMG_H(H), .XW(XW), .YW(YW), .CW(CW), .SW(SW))
        dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic stats_t model(input logic [7:0] f [N]);
        stats_t s = '{0, 0, 0, 0, 0, 0, 0};
        for (int i = 0; i < N; i++) begin
            if (f[i] != 0) begin
                int px = i % W;
                int py = i / W;
                if (s.cnt == 0) begin
                    s.min_x = px; s.max_x = px; s.min_y = py; s.max_y = py;
                end else begin
                    if (px < s.min_x) s.min_x = px;
                    if (px > s.max_x) s.max_x = px;
                    if (py < s.min_y) s.min_y = py;
                    if (py > s.max_y) s.max_y = py;
                end
                s.cnt++;
                s.sx += px;
                s.sy += py;
            end
        end
`ifndef REGION_STATS_SUMS_EN
        s.sx = 0;
        s.sy = 0;
`endif
        return s;
    endfunction

    task automatic check_outputs(input string tag, input stats_t e);
        check({tag, ".obj_present"}, 32'(bus.obj_present), 32'(e.cnt != 0));
        check({tag, ".pix_count"}, 32'(bus.pix_count), 32'(e.cnt));
        check({tag, ".min_x"}, 32'(bus.min_x), 32'(e.min_x));
        check({tag, ".max_x"}, 32'(bus.max_x), 32'(e.max_x));
        check({tag, ".min_y"}, 32'(bus.min_y), 32'(e.min_y));
        check({tag, ".max_y"}, 32'(bus.max_y), 32'(e.max_y));
        check({tag, ".sum_x"}, 32'(bus.sum_x), 32'(e.sx));
        check({tag, ".sum_y"}, 32'(bus.sum_y), 32'(e.sy));
    endtask

    task automatic drive(input logic v, input logic s, input logic [7:0] d);
        bus.pix_valid = v;
        bus.pix_sof   = s;
        bus.pix_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++)
            drive(1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
    endtask

    task automatic rand_img(input int density);
        for (int i = 0; i < N; i++)
            img[i] = ($urandom_range(0, 99) < density) ? 8'($urandom_range(1, 255)) : 8'd0;
    endtask

    task automatic play_frame(input string tag, input int gap, input logic exp_err);
        stats_t e = model(img);
        for (int i = 0; i < N; i++) begin
            if (i > 0) idle(gap);
            drive(1'b1, i == 0, img[i]);
            if (i == 0) begin
                check({tag, ".frame_err"}, 32'(bus.frame_err), 32'(exp_err));
                check({tag, ".sv_start"}, 32'(bus.stats_valid), 32'd0);
                check_outputs({tag, ".hold"}, prev);
            end else if (i == N - 1) begin
                check({tag, ".stats_valid"}, 32'(bus.stats_valid), 32'd1);
                check({tag, ".frame_err_end"}, 32'(bus.frame_err), 32'd0);
                check_outputs(tag, e);
            end else begin
                check({tag, ".sv_mid"}, 32'(bus.stats_valid), 32'd0);
            end
        end
        prev = e;
    endtask

    task automatic play_partial(input int n);
        rand_img(40);
        for (int i = 0; i < n; i++)
            drive(1'b1, i == 0, img[i]);
    endtask

    initial begin
        prev = '{0, 0, 0, 0, 0, 0, 0};
        bus.pix_valid = 1'b0;
        bus.pix_sof   = 1'b0;
        bus.pix_data  = 8'd0;
        @(posedge clk); @(posedge clk); #1;
        check("reset.stats_valid", 32'(bus.stats_valid), 32'd0);
        check("reset.frame_err", 32'(bus.frame_err), 32'd0);
        check_outputs("reset", prev);
        rst = 1'b0;

        // IDLE ignores valid beats without sof
        for (int k = 0; k < 5; k++) drive(1'b1, 1'b0, 8'hFF);

        for (int i = 0; i < N; i++) img[i] = 8'd0;
        play_frame("empty", 0, 1'b0);
        idle(1);
        check("empty.pulse_end", 32'(bus.stats_valid), 32'd0);

        for (int i = 0; i < N; i++) img[i] = 8'd0;
        img[1*W+2] = 8'hFF; img[1*W+5] = 8'hFF; img[2*W+3] = 8'hFF;
        play_frame("three", 0, 1'b0);
        idle(2);
        play_frame("three_gap", 1, 1'b0);
        idle(2);

        // Abort at beat 13, then a single object pixel at (7,3)
        play_partial(13);
        for (int i = 0; i < N; i++) img[i] = 8'd0;
        img[3*W+7] = 8'h01;
        play_frame("abort", 0, 1'b1);

        // Back-to-back: next sof lands in the DONE cycle
        for (int f = 0; f < 4; f++) begin
            rand_img(30);
            play_frame($sformatf("b2b%0d", f), (f % 2), 1'b0);
        end
        idle(1);

        for (int f = 0; f < 4; f++) begin
            rand_img(f * 30);
            play_frame($sformatf("rand%0d", f), $urandom_range(0, 1), 1'b0);
            idle($urandom_range(0, 3));
        end

        play_partial(10);
        rst = 1'b1;
        drive(1'b0, 1'b0, 8'd0);
        rst = 1'b0;
        prev = '{0, 0, 0, 0, 0, 0, 0};
        check("rst_mid.stats_valid", 32'(bus.stats_valid), 32'd0);
        check_outputs("rst_mid", prev);
        rand_img(50);
        play_frame("after_rst", 0, 1'b0);
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/region_stats.md
Name: region_stats

Overview:
- Downstream consumer of the threshold stage.
- Takes the thresholded 8-bit pixel stream in raster order. Any pixel with a nonzero value is "object".
- Accumulates per-frame blob statistics: object pixel count, bounding box, and coordinate sums.
- Presents the statistics once per frame to the navigation logic for centroid and obstacle extent.

Parameters:
- IMG_W, 320, pixels per line
- IMG_H, 240, lines per frame
- XW, 9, x coordinate width (must satisfy 2^XW >= IMG_W)
- YW, 8, y coordinate width (must satisfy 2^YW >= IMG_H)
- CW, 17, pixel count width (must satisfy 2^CW > IMG_W*IMG_H)
- SW, 26, coordinate sum width (must satisfy 2^SW > IMG_W*IMG_H*max(IMG_W,IMG_H))

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- pix_valid  in  1  pix_data is valid this cycle
- pix_sof  in  1  start of frame; qualified by pix_valid, marks pixel (0,0)
- pix_data  in  8  thresholded pixel; 0 is background, nonzero is object
- stats_valid  out  1  one-cycle pulse when a new frame result is latched
- obj_present  out  1  latched frame contained at least one object pixel
- pix_count  out  CW  object pixel count
- min_x / max_x  out  XW  bounding box columns
- min_y / max_y  out  YW  bounding box rows
- sum_x  out  SW  sum of x over object pixels
- sum_y  out  SW  sum of y over object pixels
- frame_err  out  1  one-cycle pulse when a frame is aborted

Behaviour:
- Reset: all outputs 0. State IDLE. x=0, y=0. All accumulators cleared.
- States:
  - IDLE: wait for the first frame. pix_valid without pix_sof is ignored.
  - ACCUM: collecting a frame.
  - DONE: one cycle; latches the result.
- IDLE -> ACCUM on pix_valid & pix_sof. The sof pixel is processed as (0,0); accumulators are initialised from it, not added to stale values.
- In ACCUM, each pix_valid beat:
  - If pix_data != 0: count += 1; sum_x += x; sum_y += y; update min/max. The first object pixel of a frame loads min and max directly.
  - x increments. When x == IMG_W-1, x wraps to 0 and y increments.
  - Cycles without pix_valid stall the counters; accumulators hold.
- Last pixel: the beat at x=IMG_W-1, y=IMG_H-1 goes to DONE.
- DONE (exactly 1 cycle after the last beat):
  - Copy accumulators to the outputs and pulse stats_valid.
  - Return to IDLE.
  - If pix_valid & pix_sof arrives in the DONE cycle, it starts the next frame (go to ACCUM with that pixel processed). There is no dead cycle.
- Outputs hold their values until the next DONE.
- Empty frame: obj_present=0, pix_count=0, min/max/sums all 0, stats_valid still pulses.
- sof mid-frame (ACCUM, not on pixel (0,0)):
  - Pulse frame_err.
  - Discard the partial accumulators.
  - Restart the frame with this pixel as (0,0).
  - Previously latched outputs are unchanged; stats_valid does not pulse.
- pix_sof while pix_valid=0 is ignored.
- rst mid-frame: return to reset state next cycle; the partial frame is discarded and outputs are cleared.
- Widths: sums and count never overflow given the parameter constraints; arithmetic is unsigned.

Optional Feature:
- REGION_STATS_SUMS_EN
- Defined: the sum_x/sum_y accumulators and output registers are built as described.
- Undefined: no sum logic is instantiated; sum_x and sum_y are tied to 0. All other behaviour is identical.

Test Plan:
- IMG_W=8, IMG_H=4; all-zero frame. Expect: stats_valid pulse 1 cycle after the 32nd beat; obj_present=0, count=0, bbox=0, sums=0.
- Object pixels at (2,1), (5,1), (3,2), value 0xFF. Expect: count=3, min_x=2, max_x=5, min_y=1, max_y=2, sum_x=10, sum_y=4, obj_present=1.
- Same frame with pix_valid deasserted every other cycle. Expect: identical results; stats_valid pulses 1 cycle after the last valid beat.
- sof re-asserted at beat 13 of a frame, then a clean frame with a single pixel at (7,3). Expect: frame_err pulse at beat 13, no stats_valid for the aborted frame; then count=1, min_x=max_x=7, min_y=max_y=3, sum_x=7, sum_y=3.
- Back-to-back frames with the second sof in the DONE cycle. Expect: both stats_valid pulses present; second result correct.
- rst asserted mid-frame, then a full frame. Expect: outputs 0 after reset; next frame results correct. With REGION_STATS_SUMS_EN undefined: sum_x=sum_y=0 throughout.
